// File: rtl/mem_responder.sv
// Word-addressed memory slave with a fixed number of wait states and a one-cycle response strobe.
// Misaligned or out-of-range accesses complete with err=1 and leave memory and ReadData untouched.
module mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        ready,
  output logic        err,
  output logic        busy
);
  localparam int         AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [3:0]    r_wait;
  logic          r_write;
  logic          r_err;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [DEPTH];

  logic          w_accept;
  logic          w_to_resp;
  logic          w_op_write;
  logic          w_op_err;
  logic          w_mem_we;
  logic [31:0]   w_op_addr;
  logic [31:0]   w_op_wdata;
  logic [AW-1:0] w_op_idx;

  // With zero wait states the access completes on the accepting edge, so the
  // operands must come straight from the ports rather than from the latches.
  assign w_accept   = (r_state == IDLE) && req;
  assign w_op_write = (r_state == IDLE) ? MemWrite  : r_write;
  assign w_op_addr  = (r_state == IDLE) ? Addr      : r_addr;
  assign w_op_wdata = (r_state == IDLE) ? WriteData : r_wdata;
  assign w_op_idx   = w_op_addr[AW+1:2];
  assign w_op_err   = (w_op_addr[1:0] != 2'b00) ||
                      ({2'b00, w_op_addr[31:2]} >= 32'(DEPTH));
  assign w_mem_we   = w_to_resp && w_op_write && !w_op_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_to_resp    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            w_state_next = RESP;
            w_to_resp    = 1'b1;
          end else begin
            w_state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (r_wait == 4'd1) begin
          w_state_next = RESP;
          w_to_resp    = 1'b1;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait  <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      if (w_accept) begin
        r_wait  <= WS;
        r_write <= MemWrite;
        r_addr  <= Addr;
        r_wdata <= WriteData;
      end else if (r_state == BUSY) begin
        r_wait <= r_wait - 4'd1;
      end
      if (w_to_resp) begin
        r_err <= w_op_err;
        if (!w_op_write && !w_op_err) begin
          r_rdata <= r_mem[w_op_idx];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (w_mem_we) begin
      r_mem[w_op_idx] <= w_op_wdata;
    end
  end

  assign ready    = (r_state == RESP);
  assign err      = ready && r_err;
  assign busy     = (r_state != IDLE);
  assign ReadData = r_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a behavioural memory model predicts each response,
// monitors pop and compare whenever ready pulses. A second instance covers WAIT_STATES=0.
module tb_mem_responder;
  logic        clk;
  logic        reset;
  logic        req, MemWrite;
  logic [31:0] Addr, WriteData, ReadData;
  logic        ready, err, busy;
  logic        req0, we0;
  logic [31:0] addr0, wd0, rd0;
  logic        ready0, err0, busy0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        q[$];
  exp_t        q0[$];
  exp_t        mon_e, mon_e0, tmp_e;
  logic [31:0] m_mem [64];
  logic [31:0] m_rdata;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ready_cnt = 0;
  int          last_ready_cyc = 0;
  int          prev_ready_cyc = 0;
  int          cnt_before;

  mem_responder #(.DEPTH(64), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .req(req), .MemWrite(MemWrite), .Addr(Addr),
    .WriteData(WriteData), .ReadData(ReadData), .ready(ready), .err(err), .busy(busy)
  );

  mem_responder #(.DEPTH(64), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .MemWrite(we0), .Addr(addr0),
    .WriteData(wd0), .ReadData(rd0), .ready(ready0), .err(err0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic we, input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    logic [29:0] w;
    w     = a[31:2];
    e.err = (a[1:0] != 2'b00) || (w >= 30'd64);
    if (!e.err && we) m_mem[w[5:0]] = d;
    if (!e.err && !we) m_rdata = m_mem[w[5:0]];
    e.rdata = m_rdata;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_mem[i] = 32'd0;
    m_rdata = 32'd0;
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge with it idle again.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; MemWrite = we; Addr = a; WriteData = d;
    @(posedge clk); #1;
    q.push_back(model(we, a, d));
    req = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'd1);
      chk("ready_timing", 32'(ready), 32'(i == 3));
    end
    @(negedge clk);
    chk("busy_end", 32'(busy), 32'd0);
  endtask

  task automatic access0(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rdata);
    req0 = 1'b1; we0 = we; addr0 = a; wd0 = d;
    @(posedge clk); #1;
    tmp_e.rdata = exp_rdata;
    tmp_e.err   = 1'b0;
    q0.push_back(tmp_e);
    req0 = 1'b0;
    @(negedge clk);
    chk("ws0_ready", 32'(ready0), 32'd1);
    chk("ws0_busy", 32'(busy0), 32'd1);
    @(negedge clk);
    chk("ws0_idle", 32'(busy0), 32'd0);
  endtask

  always @(negedge clk) begin
    if (ready) begin
      ready_cnt++;
      prev_ready_cyc = last_ready_cyc;
      last_ready_cyc = cyc;
      chk("pending_on_ready", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        $display("resp cyc=%0d rdata=%h err=%0b (exp %h/%0b)", cyc, ReadData, err, mon_e.rdata, mon_e.err);
        chk("rdata", ReadData, mon_e.rdata);
        chk("err", 32'(err), 32'(mon_e.err));
      end
    end else begin
      chk("err_without_ready", 32'(err), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (ready0) begin
      chk("pending_on_ready0", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        mon_e0 = q0.pop_front();
        $display("resp0 cyc=%0d rdata=%h err=%0b (exp %h/%0b)", cyc, rd0, err0, mon_e0.rdata, mon_e0.err);
        chk("rdata0", rd0, mon_e0.rdata);
        chk("err0", 32'(err0), 32'(mon_e0.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; req = 1'b0; MemWrite = 1'b0; Addr = 32'd0; WriteData = 32'd0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wd0 = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", ReadData, 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    reset = 1'b1;

    access(1'b1, 32'h10, 32'hDEADBEEF);
    access(1'b0, 32'h10, 32'd0);
    access(1'b0, 32'h12, 32'd0);
    access(1'b1, 32'h100, 32'h5555AAAA);
    access(1'b0, 32'h0, 32'd0);

    for (int k = 0; k < 8; k++) access(1'b1, 32'(k * 4), 32'h1000 + 32'(k));

    // req held with a new address every cycle: only the idle-cycle samples are taken
    cnt_before = ready_cnt;
    req = 1'b1; MemWrite = 1'b0;
    for (int k = 0; k < 8; k++) begin
      Addr = 32'(k * 4);
      @(posedge clk); #1;
      if (k == 0 || k == 4) q.push_back(model(1'b0, 32'(k * 4), 32'd0));
    end
    req = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_req_pulses", 32'(ready_cnt - cnt_before), 32'd2);

    // back-to-back reads of 0x0 then 0x4 with req held
    req = 1'b1; MemWrite = 1'b0; Addr = 32'h0;
    @(posedge clk); #1;
    q.push_back(model(1'b0, 32'h0, 32'd0));
    Addr = 32'h4;
    for (int k = 1; k < 6; k++) begin
      @(posedge clk); #1;
      if (k == 4) q.push_back(model(1'b0, 32'h4, 32'd0));
    end
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_gap", 32'(last_ready_cyc - prev_ready_cyc), 32'd4);

    // reset in the middle of a write aborts it
    access(1'b1, 32'h20, 32'h0000CAFE);
    req = 1'b1; MemWrite = 1'b1; Addr = 32'h24; WriteData = 32'h12345678;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("inrst_busy", 32'(busy), 32'd0);
    chk("inrst_ready", 32'(ready), 32'd0);
    chk("inrst_err", 32'(err), 32'd0);
    chk("inrst_rdata", ReadData, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    access(1'b0, 32'h20, 32'd0);
    access(1'b0, 32'h24, 32'd0);

    access0(1'b1, 32'hFC, 32'hA5A5A5A5, 32'd0);
    access0(1'b0, 32'hFC, 32'd0, 32'hA5A5A5A5);

    repeat (2) @(negedge clk);
    chk("q_empty", 32'(q.size()), 32'd0);
    chk("q0_empty", 32'(q0.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, giving the number of 32-bit words stored.
REQ-002 The block SHALL have parameter WAIT_STATES, default 2, giving the number of BUSY cycles per access (legal range 0..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port req, input, 1 bit: an access request, sampled only in IDLE.
REQ-006 The block SHALL have port MemWrite, input, 1 bit: 1 = write access, 0 = read access; qualifies req.
REQ-007 The block SHALL have port Addr, input, 32 bits: the byte address; the word index is Addr[31:2].
REQ-008 The block SHALL have port WriteData, input, 32 bits: the write data.
REQ-009 The block SHALL have port ReadData, output, 32 bits: the read data, valid when ready=1 and MemWrite was 0 at accept.
REQ-010 The block SHALL have port ready, output, 1 bit: a one-cycle response strobe.
REQ-011 The block SHALL have port err, output, 1 bit: an error flag, valid only with ready=1.
REQ-012 The block SHALL have port busy, output, 1 bit: 1 whenever the state is not IDLE.

Function
REQ-013 The block SHALL implement the states IDLE, BUSY and RESP, with IDLE as the reset state.
REQ-014 In IDLE with req=1, the block SHALL accept the request on the rising edge: latch MemWrite, Addr and WriteData, load the wait counter with WAIT_STATES, and go to BUSY (or to RESP if WAIT_STATES=0).
REQ-015 In IDLE with req=0, the block SHALL remain in IDLE.
REQ-016 In BUSY, the block SHALL decrement the wait counter each cycle and go to RESP on the edge where the counter equals 1.
REQ-017 In RESP, the block SHALL drive ready=1 for exactly one cycle and then return to IDLE unconditionally.
REQ-018 The response latency SHALL be WAIT_STATES+1 edges: ready is high in the cycle after the (WAIT_STATES+1)th edge following acceptance.
REQ-019 While busy=1, the block SHALL ignore req, MemWrite, Addr and WriteData; such a request is not queued.
REQ-020 A request presented in the RESP cycle SHALL be ignored; the earliest new acceptance is the edge that leaves RESP plus one cycle (IDLE).
REQ-021 The latched address SHALL be flagged as an error if Addr[1:0] is not 0 (misaligned) or if Addr[31:2] >= DEPTH (out of range).
REQ-022 For an error access, the block SHALL assert err=1 with ready, leave the array unmodified, and leave ReadData unchanged.
REQ-023 A valid write SHALL update array[Addr[31:2]] on the edge entering RESP; err=0 and ReadData are unchanged.
REQ-024 A valid read SHALL load ReadData from array[Addr[31:2]] on the edge entering RESP.
REQ-025 ReadData SHALL hold its value until the next valid read response.
REQ-026 A read following a write to the same word SHALL return the newly written data.
REQ-027 err SHALL be 0 whenever ready=0.

Reset
REQ-028 While reset=0, the block SHALL asynchronously force state=IDLE, wait counter=0, ready=0, err=0, busy=0, ReadData=0x00000000 and every array word to 0x00000000.
REQ-029 Assertion of reset during BUSY or RESP SHALL abort the access: any pending write is discarded and no ready pulse is produced.
REQ-030 After reset is released, the first rising edge with req=1 SHALL be accepted.

Verification
REQ-031 Bench: reset, then write Addr=0x10, WriteData=0xDEADBEEF, then read Addr=0x10 -> each access gives busy=1 for 3 cycles, with ready=1 and err=0 in the 3rd; the read returns ReadData=0xDEADBEEF.
REQ-032 Bench: read Addr=0x12 -> ready=1 with err=1, ReadData keeps its prior value; write Addr=0x100 (word 64, DEPTH=64) -> err=1, and a following read of 0x0 returns 0x00000000.
REQ-033 Bench: req held at 1 with changing Addr throughout a BUSY period -> only the first request is accepted, the others are ignored; ready pulses once per accepted access, and the next acceptance occurs in the IDLE cycle after RESP.
REQ-034 Bench: write 0x0000CAFE to 0x20, then pulse reset=0 mid-BUSY of a write of 0x12345678 to 0x24 -> no ready pulse occurs, reads of 0x20 and 0x24 both return 0x00000000, and all outputs are 0 during reset.
REQ-035 Bench: WAIT_STATES=0, read of 0xFC after writing 0xA5A5A5A5 there -> ready=1 in the cycle after the accepting edge, with ReadData=0xA5A5A5A5.
REQ-036 Bench: back-to-back reads of 0x0 and 0x4 with req held at 1 -> acceptances are 4 cycles apart (WAIT_STATES=2) and both responses have err=0.
